// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder driving an external registered 1-bit full-adder cell.
// Two cycles per bit (ISSUE lets the cell register, CAPT collects); result held until accepted.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IW-1:0] idx;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    // Operand registers keep the not-yet-issued bits right-aligned, so bit 0 is always the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx <= '0;
            result <= '0;
            cout <= 1'b0;
            out_valid <= 1'b0;
            fa_a <= 1'b0;
            fa_b <= 1'b0;
            fa_c <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= op_a >> 1;
                    b_reg <= op_b >> 1;
                    fa_a <= op_a[0];
                    fa_b <= op_b[0];
                    fa_c <= cin;
                    idx <= '0;
                    result <= '0;
                    state <= ISSUE;
                end
                ISSUE: state <= CAPT;
                CAPT: begin
                    result[idx] <= fa_sum;
                    if (idx == IW'(WIDTH - 1)) begin
                        cout <= fa_carry;
                        out_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        fa_a <= a_reg[0];
                        fa_b <= b_reg[0];
                        fa_c <= fa_carry;
                        a_reg <= a_reg >> 1;
                        b_reg <= b_reg >> 1;
                        idx <= idx + 1'b1;
                        state <= ISSUE;
                    end
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: checks serial_add_seq at WIDTH 8, 1 and 16 against plain integer addition.
module tb_serial_add_seq;
    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready, cin;
    logic [31:0] op_a, op_b;
    int sel;
    int checks = 0;
    int errors = 0;
    logic [31:0] res_v [3];
    logic rdy_v [3], ov_v [3], busy_v [3], cout_v [3], fa_a_v [3], fa_b_v [3], fa_c_v [3];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g == 0 ? 8 : g == 1 ? 1 : 16;
        logic [W-1:0] res;
        logic iv, rdy, ov, bsy, co, fa, fb, fc, s, cy;
        assign iv = in_valid && sel == g;
        serial_add_seq #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy),
            .op_a(op_a[W-1:0]), .op_b(op_b[W-1:0]), .cin(cin),
            .out_valid(ov), .out_ready(out_ready), .result(res), .cout(co), .busy(bsy),
            .fa_a(fa), .fa_b(fb), .fa_c(fc), .fa_sum(s), .fa_carry(cy)
        );
        // Registered full-adder cell model sharing the sequencer's reset.
        always @(posedge clk or posedge rst)
            if (rst) {cy, s} <= 2'b00;
            else {cy, s} <= 2'(fa) + 2'(fb) + 2'(fc);
        assign res_v[g] = 32'(res);
        assign rdy_v[g] = rdy;
        assign ov_v[g] = ov;
        assign busy_v[g] = bsy;
        assign cout_v[g] = co;
        assign fa_a_v[g] = fa;
        assign fa_b_v[g] = fb;
        assign fa_c_v[g] = fc;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    function automatic int wd();
        return sel == 0 ? 8 : sel == 1 ? 1 : 16;
    endfunction
    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic c, input int hold,
                       input bit keep, input logic [31:0] na, input logic [31:0] nb, input logic nc);
        logic [31:0] m;
        logic [32:0] full;
        int k;
        m = (32'd1 << wd()) - 32'd1;
        full = 33'(a & m) + 33'(b & m) + 33'(c);
        op_a = a;
        op_b = b;
        cin = c;
        in_valid = 1'b1;
        k = 0;
        while (!rdy_v[sel] && k < 100) begin step(); k++; end
        chk("accept_wait", 64'(k < 100), 64'd1);
        step();
        chk("busy_after_accept", 64'(busy_v[sel]), 64'd1);
        chk("fa_bit0", 64'({fa_a_v[sel], fa_b_v[sel], fa_c_v[sel]}), 64'({a[0], b[0], c}));
        if (keep) begin op_a = na; op_b = nb; cin = nc; end
        else in_valid = 1'b0;
        k = 0;
        while (!ov_v[sel] && k < 100) begin step(); k++; end
        chk("latency", 64'(k), 64'(2 * wd()));
        chk("result", 64'(res_v[sel]), 64'(full[31:0] & m));
        chk("cout", 64'(cout_v[sel]), 64'(full[wd()]));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_valid", 64'({ov_v[sel], busy_v[sel], rdy_v[sel]}), 64'(3'b110));
            chk("bp_result", 64'({cout_v[sel], res_v[sel]}), 64'({full[wd()], full[31:0] & m}));
        end
        out_ready = 1'b1;
        step();
        chk("after_xfer", 64'({ov_v[sel], busy_v[sel], rdy_v[sel]}), 64'(3'b001));
    endtask
    initial begin
        sel = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        cin = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_hs", 64'({rdy_v[0], ov_v[0], busy_v[0]}), 64'(3'b100));
        chk("rst_out", 64'({cout_v[0], res_v[0]}), 64'd0);
        chk("rst_fa", 64'({fa_a_v[0], fa_b_v[0], fa_c_v[0]}), 64'd0);
        rst = 1'b0;
        add(32'h5A, 32'h3C, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        add(32'hFF, 32'h01, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        add(32'hFF, 32'hFF, 1'b1, 0, 1'b0, 0, 0, 1'b0);
        add(32'h00, 32'h00, 1'b1, 0, 1'b1, 32'h12, 32'h34, 1'b0);
        add(32'h12, 32'h34, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        add(32'hC3, 32'h7E, 1'b1, 5, 1'b0, 0, 0, 1'b0);
        op_a = 32'hAA;
        op_b = 32'h55;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hs", 64'({rdy_v[0], ov_v[0], busy_v[0]}), 64'(3'b100));
        chk("mid_rst_out", 64'({cout_v[0], res_v[0]}), 64'd0);
        chk("mid_rst_fa", 64'({fa_a_v[0], fa_b_v[0], fa_c_v[0]}), 64'd0);
        #2 rst = 1'b0;
        add(32'h01, 32'h01, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            add($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 0, 0, 1'b0);
        end
        sel = 1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            add(32'(v[2]), 32'(v[1]), v[0], i % 3, 1'b0, 0, 0, 1'b0);
        end
        sel = 2;
        add(32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            add($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 0, 0, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
